// File: rtl/ntt_bram_port_adapter.sv
// ntt_bram_port_adapter
//
// Bridges the byte-addressed, 32-bit-word BRAM port of the AXI data slave to
// the coefficient memory banks of the NTT core. Every bus request is decoded
// into a bank/coefficient access, checked for legality, and answered in
// request order:
//   - write: bus_wack one cycle after the request.
//   - read:  bus_rvalid RD_LAT+2 cycles after the request.
// Illegal requests never touch memory. They still get a response with bus_err
// set, and they are tallied in a saturating err_count.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   bus_en/we/addr/wdata        bus request (one per cycle, no backpressure)
//   bus_rdata/rvalid/wack/err   bus responses
//   core_busy                   NTT running; requests in that cycle are rejected
//   mem_en/we/bank/addr/din     registered coefficient-memory request
//   mem_dout                    memory read data, RD_LAT cycles after mem_en
//   err_count                   saturating count of rejected accesses
module ntt_bram_port_adapter #(
  parameter int COEF_W     = 12,
  parameter int Q          = 3329,
  parameter int N_COEF     = 256,
  parameter int N_BANK     = 2,
  parameter int BUS_ADDR_W = 12,
  parameter int BUS_DATA_W = 32,
  parameter int RD_LAT     = 1,
  localparam int BANK_W    = (N_BANK > 1) ? $clog2(N_BANK) : 1,
  localparam int CIDX_W    = $clog2(N_COEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_en,
  input  logic                  bus_we,
  input  logic [BUS_ADDR_W-1:0] bus_addr,
  input  logic [BUS_DATA_W-1:0] bus_wdata,
  output logic [BUS_DATA_W-1:0] bus_rdata,
  output logic                  bus_rvalid,
  output logic                  bus_wack,
  output logic                  bus_err,
  input  logic                  core_busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [BANK_W-1:0]     mem_bank,
  output logic [CIDX_W-1:0]     mem_addr,
  output logic [COEF_W-1:0]     mem_din,
  input  logic [COEF_W-1:0]     mem_dout,
  output logic [7:0]            err_count
);

  localparam int unsigned TAG_DEPTH = RD_LAT + 1;

  typedef struct packed {
    logic is_read;
    logic err;
  } tag_t;

  // Request decode
  logic [BUS_ADDR_W-1:0] word_idx;
  logic [BUS_ADDR_W-1:0] bank_full;
  logic [BANK_W-1:0]     bank_sel;
  logic [CIDX_W-1:0]     coef_sel;
  logic                  bank_ok;
  logic                  wdata_ok;
  logic                  illegal;
  logic                  accept;

  always_comb begin
    word_idx  = bus_addr >> 2;
    bank_full = word_idx >> CIDX_W;
    bank_sel  = BANK_W'(bank_full);
    coef_sel  = word_idx[CIDX_W-1:0];
    bank_ok   = bank_full < BUS_ADDR_W'(N_BANK);
    wdata_ok  = bus_wdata < BUS_DATA_W'(Q);
    illegal   = (bus_addr[1:0] != 2'b00) || !bank_ok || core_busy ||
                (bus_we && !wdata_ok);
    accept    = bus_en && !illegal;
  end

  // Registered state
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [BANK_W-1:0]     mem_bank_q;
  logic [CIDX_W-1:0]     mem_addr_q;
  logic [COEF_W-1:0]     mem_din_q;
  logic                  wack_q;
  logic                  rvalid_q;
  logic                  err_q;
  logic [BUS_DATA_W-1:0] rdata_q;
  logic [7:0]            err_count_q;
  logic [7:0]            err_count_d;
  tag_t                  tag_q [TAG_DEPTH];

  // Error sources that become visible at the next edge: a rejected write is
  // acknowledged one cycle after its request, while a rejected read surfaces
  // when its tag leaves the latency chain. Both may coincide.
  logic wr_err;
  logic rd_err;
  logic rd_ok;
  logic [8:0] err_sum;

  always_comb begin
    wr_err  = bus_en && bus_we && illegal;
    rd_err  = tag_q[RD_LAT].is_read && tag_q[RD_LAT].err;
    rd_ok   = tag_q[RD_LAT].is_read && !tag_q[RD_LAT].err;
    err_sum = {1'b0, err_count_q} + 9'(wr_err) + 9'(rd_err);
    err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_bank_q  <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      wack_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      err_count_q <= '0;
      for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      mem_en_q <= accept;
      mem_we_q <= accept && bus_we;
      // Address/data only move on accepted requests; with mem_en low they are
      // don't-care for the memory, so holding them saves toggling.
      if (accept) begin
        mem_bank_q <= bank_sel;
        mem_addr_q <= coef_sel;
        mem_din_q  <= bus_wdata[COEF_W-1:0];
      end

      // Tag stage i describes the request made i+1 cycles ago; the last stage
      // lines up with mem_dout of that request.
      tag_q[0] <= '{is_read: bus_en && !bus_we, err: illegal};
      for (int unsigned i = 1; i < TAG_DEPTH; i++) begin
        tag_q[i] <= tag_q[i-1];
      end

      wack_q      <= bus_en && bus_we;
      rvalid_q    <= tag_q[RD_LAT].is_read;
      rdata_q     <= rd_ok ? BUS_DATA_W'(mem_dout) : '0;
      err_q       <= wr_err || rd_err;
      err_count_q <= err_count_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_bank   = mem_bank_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign bus_wack   = wack_q;
  assign bus_rvalid = rvalid_q;
  assign bus_err    = err_q;
  assign bus_rdata  = rdata_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_ntt_bram_port_adapter.sv
// Drives two adapters (RD_LAT=1 and RD_LAT=3) with the same directed request
// stream. Each instance has its own BRAM model and a cycle-indexed reference
// schedule of expected outputs; every cycle both are compared at the falling
// edge, alongside literal checks at hand-computed points.
module tb_ntt_bram_port_adapter;

  localparam int CYC_MAX = 1024;

  typedef struct packed {
    logic        wack;
    logic        rvalid;
    logic        werr;
    logic        rerr;
    logic [31:0] rdata;
    logic        men;
    logic        mwe;
    logic        mbank;
    logic [7:0]  maddr;
    logic [11:0] mdin;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        bus_en;
  logic        bus_we;
  logic        core_busy;
  logic [11:0] bus_addr;
  logic [31:0] bus_wdata;

  int errors = 0;
  int checks = 0;

  function automatic logic [11:0] init_val(int unsigned b, int unsigned c);
    return 12'(((b * 256) + c) * 37 % 3329);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : ln
    localparam int LAT = (g == 0) ? 1 : 3;

    logic [31:0] rdata;
    logic        rvalid;
    logic        wack;
    logic        berr;
    logic        men;
    logic        mwe;
    logic [0:0]  mbank;
    logic [7:0]  maddr;
    logic [11:0] mdin;
    logic [11:0] mdout;
    logic [7:0]  ecnt;

    ntt_bram_port_adapter #(
      .COEF_W(12), .Q(3329), .N_COEF(256), .N_BANK(2),
      .BUS_ADDR_W(12), .BUS_DATA_W(32), .RD_LAT(LAT)
    ) dut (
      .clk(clk), .rst(rst),
      .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(rdata), .bus_rvalid(rvalid), .bus_wack(wack), .bus_err(berr),
      .core_busy(core_busy),
      .mem_en(men), .mem_we(mwe), .mem_bank(mbank), .mem_addr(maddr), .mem_din(mdin),
      .mem_dout(mdout), .err_count(ecnt)
    );

    // Synchronous BRAM with LAT cycles of read latency
    logic [11:0] bram [2][256];
    logic [11:0] pipe [3];
    bit          bram_init = 1'b0;

    always @(posedge clk) begin
      if (!bram_init) begin
        for (int b = 0; b < 2; b++)
          for (int c = 0; c < 256; c++)
            bram[b][c] = init_val(b, c);
        bram_init = 1'b1;
      end
      if (men) begin
        if (mwe) bram[mbank][maddr] = mdin;
        else     pipe[0] <= bram[mbank][maddr];
      end
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mdout = pipe[LAT-1];

    // Reference: sched[c] holds what the outputs must be in cycle c, where
    // cycle c follows the c-th rising edge. A request seen at edge k lands its
    // memory access/write ack in cycle k and its read response in k+1+LAT.
    exp_t        sched [CYC_MAX];
    logic [11:0] shadow [2][256];
    bit          sh_init = 1'b0;
    int unsigned k = 0;
    int          cnt = 0;
    exp_t        expv;
    logic [7:0]  exp_cnt;

    always @(posedge clk) begin
      int unsigned idx, bank, coef, r;
      bit bad;
      if (!sh_init) begin
        for (int b = 0; b < 2; b++)
          for (int c = 0; c < 256; c++)
            shadow[b][c] = init_val(b, c);
        sh_init = 1'b1;
      end
      k++;
      if (rst) begin
        for (int unsigned i = k; i < CYC_MAX; i++) sched[i] = '0;
        cnt = 0;
      end else begin
        if (bus_en) begin
          idx  = 32'(bus_addr) / 4;
          bank = idx / 256;
          coef = idx % 256;
          bad  = (bus_addr % 4 != 0) || (bank >= 2) || core_busy ||
                 (bus_we && bus_wdata >= 32'd3329);
          if (bus_we) begin
            sched[k].wack = 1'b1;
            sched[k].werr = bad;
            if (!bad) shadow[bank][coef] = bus_wdata[11:0];
          end else begin
            r = k + 1 + LAT;
            sched[r].rvalid = 1'b1;
            sched[r].rerr   = bad;
            sched[r].rdata  = bad ? 32'd0 : {20'd0, shadow[bank][coef]};
          end
          if (!bad) begin
            sched[k].men   = 1'b1;
            sched[k].mwe   = bus_we;
            sched[k].mbank = bank[0];
            sched[k].maddr = coef[7:0];
            sched[k].mdin  = bus_wdata[11:0];
          end
        end
        cnt = cnt + int'(sched[k].werr) + int'(sched[k].rerr);
        if (cnt > 255) cnt = 255;
      end
      expv    = sched[k];
      exp_cnt = 8'(cnt);
    end
  end

  task automatic check(input string nm, input int lane, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d @%0t: got %0h expected %0h", nm, lane, $time, act, exp);
    end
  endtask

  task automatic chk_lane(input int L, input exp_t e, input logic [7:0] ec,
                          input logic wack, input logic rvalid, input logic berr,
                          input logic men, input logic mwe, input logic mb,
                          input logic [7:0] ma, input logic [11:0] md,
                          input logic [31:0] rd, input logic [7:0] cnt);
    check("wack", L, 32'(wack), 32'(e.wack));
    check("rvalid", L, 32'(rvalid), 32'(e.rvalid));
    check("err", L, 32'(berr), 32'(e.werr | e.rerr));
    check("mem_en", L, 32'(men), 32'(e.men));
    check("err_count", L, 32'(cnt), 32'(ec));
    if (e.rvalid) check("rdata", L, rd, e.rdata);
    if (e.men) begin
      check("mem_we", L, 32'(mwe), 32'(e.mwe));
      check("mem_bank", L, 32'(mb), 32'(e.mbank));
      check("mem_addr", L, 32'(ma), 32'(e.maddr));
      check("mem_din", L, 32'(md), 32'(e.mdin));
    end else begin
      check("mem_we_idle", L, 32'(mwe), 32'd0);
    end
  endtask

  task automatic check_all();
    chk_lane(0, ln[0].expv, ln[0].exp_cnt, ln[0].wack, ln[0].rvalid, ln[0].berr,
             ln[0].men, ln[0].mwe, ln[0].mbank[0], ln[0].maddr, ln[0].mdin,
             ln[0].rdata, ln[0].ecnt);
    chk_lane(1, ln[1].expv, ln[1].exp_cnt, ln[1].wack, ln[1].rvalid, ln[1].berr,
             ln[1].men, ln[1].mwe, ln[1].mbank[0], ln[1].maddr, ln[1].mdin,
             ln[1].rdata, ln[1].ecnt);
  endtask

  task automatic step(input logic en, input logic we, input logic [11:0] a,
                      input logic [31:0] d, input logic busy);
    bus_en    = en;
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = d;
    core_busy = busy;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 12'h000, 32'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; core_busy = 1'b0;
    idle(2);
    check("lit_reset_rvalid", 0, 32'(ln[0].rvalid), 32'd0);
    check("lit_reset_cnt", 1, 32'(ln[1].ecnt), 32'd0);
    rst = 1'b0;
    idle(1);

    // Write 0xABC to 0x008, read it straight back
    step(1, 1, 12'h008, 32'h0000_0ABC, 0);
    check("lit_w_addr", 0, 32'(ln[0].maddr), 32'd2);
    check("lit_w_bank", 0, 32'(ln[0].mbank), 32'd0);
    check("lit_w_wack", 0, 32'(ln[0].wack), 32'd1);
    check("lit_w_err", 0, 32'(ln[0].berr), 32'd0);
    step(1, 0, 12'h008, 32'd0, 0);
    idle(2);
    check("lit_r_rvalid", 0, 32'(ln[0].rvalid), 32'd1);
    check("lit_r_rdata", 0, ln[0].rdata, 32'h0000_0ABC);
    idle(2);
    check("lit_r3_rdata", 1, ln[1].rdata, 32'h0000_0ABC);

    // Bank decode and out-of-range bank
    step(1, 0, 12'h400, 32'd0, 0);
    check("lit_bank1", 0, 32'(ln[0].mbank), 32'd1);
    check("lit_coef0", 0, 32'(ln[0].maddr), 32'd0);
    step(1, 0, 12'h800, 32'd0, 0);
    check("lit_oob_men", 0, 32'(ln[0].men), 32'd0);
    idle(2);
    check("lit_oob_rdata", 0, ln[0].rdata, 32'd0);
    check("lit_oob_err", 0, 32'(ln[0].berr), 32'd1);
    check("lit_oob_cnt", 0, 32'(ln[0].ecnt), 32'd1);
    idle(2);
    check("lit_oob_cnt3", 1, 32'(ln[1].ecnt), 32'd1);

    // Value range at Q, and a full-width compare with high bits set
    step(1, 1, 12'h010, 32'h0000_0D01, 0);
    check("lit_q_err", 0, 32'(ln[0].berr), 32'd1);
    check("lit_q_men", 0, 32'(ln[0].men), 32'd0);
    step(1, 1, 12'h010, 32'h0000_0D00, 0);
    check("lit_qm1_din", 0, 32'(ln[0].mdin), 32'h0000_0D00);
    check("lit_qm1_err", 0, 32'(ln[0].berr), 32'd0);
    step(1, 1, 12'h014, 32'h1000_0005, 0);
    check("lit_hi_err", 0, 32'(ln[0].berr), 32'd1);
    step(0, 1, 12'h008, 32'h0000_0123, 0);
    check("lit_noen_men", 0, 32'(ln[0].men), 32'd0);

    // Back-to-back reads, in-order responses
    step(1, 1, 12'h000, 32'h111, 0);
    step(1, 1, 12'h004, 32'h222, 0);
    step(1, 1, 12'h00C, 32'h333, 0);
    step(1, 0, 12'h000, 32'd0, 0);
    step(1, 0, 12'h004, 32'd0, 0);
    step(1, 0, 12'h00C, 32'd0, 0);
    idle(2);
    check("lit_b2b_0", 1, ln[1].rdata, 32'h111);
    idle(1);
    check("lit_b2b_1", 1, ln[1].rdata, 32'h222);
    idle(1);
    check("lit_b2b_2", 1, ln[1].rdata, 32'h333);
    check("lit_b2b_v", 1, 32'(ln[1].rvalid), 32'd1);

    // core_busy lockout, then the same read succeeds
    step(1, 0, 12'h010, 32'd0, 1);
    idle(2);
    check("lit_busy_err", 0, 32'(ln[0].berr), 32'd1);
    check("lit_busy_rv", 0, 32'(ln[0].rvalid), 32'd1);
    idle(3);
    step(1, 0, 12'h010, 32'd0, 0);
    idle(2);
    check("lit_unbusy_rd", 0, ln[0].rdata, 32'h0000_0D00);
    idle(3);

    // Unaligned read whose response collides with a bad-bank write ack
    step(1, 0, 12'h002, 32'd0, 0);
    idle(1);
    step(1, 1, 12'hC00, 32'd5, 0);
    check("lit_col_wack", 0, 32'(ln[0].wack), 32'd1);
    check("lit_col_rv", 0, 32'(ln[0].rvalid), 32'd1);
    check("lit_col_err", 0, 32'(ln[0].berr), 32'd1);
    idle(5);

    // Legal read in lane1 lining up with a legal write ack
    step(1, 0, 12'h004, 32'd0, 0);
    idle(3);
    step(1, 1, 12'h018, 32'h0000_0042, 0);
    idle(5);

    // Saturate err_count
    for (int i = 0; i < 260; i++) step(1, 1, 12'h020, 32'hFFFF_FFFF, 0);
    idle(5);
    check("lit_sat0", 0, 32'(ln[0].ecnt), 32'd255);
    check("lit_sat1", 1, 32'(ln[1].ecnt), 32'd255);

    // Reset with reads in flight
    step(1, 0, 12'h000, 32'd0, 0);
    step(1, 0, 12'h004, 32'd0, 0);
    rst = 1'b1;
    idle(1);
    check("lit_rst_rv", 0, 32'(ln[0].rvalid), 32'd0);
    check("lit_rst_cnt", 0, 32'(ln[0].ecnt), 32'd0);
    check("lit_rst_men", 1, 32'(ln[1].men), 32'd0);
    rst = 1'b0;
    idle(6);
    step(1, 0, 12'h008, 32'd0, 0);
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
